// File: rtl/dmem_access_unit.sv
// ============================================================================
// dmem_access_unit
//
// Memory-side responder for the decoder's data-memory control outputs.
// Takes one load/store request per VALID/READY handshake, drives a single-port
// word-addressed data memory, and returns a one-cycle response strobe.
// Store data and byte enables are shifted into their byte lanes. Load data is
// extracted from its lanes and then sign- or zero-extended. Misaligned and
// illegal requests get an error response and never reach the memory.
//
// Optional feature macro: DMEM_TIMEOUT_EN
//   defined   -> ACCESS gives up after TIMEOUT cycles without MEM_ACK and
//                responds with RESP_ERR=1, RESP_RDATA=0.
//   undefined -> ACCESS waits for MEM_ACK indefinitely.
//
// Ports:
//   CLK, RSTn      rising-edge clock, synchronous active-low reset
//   REQ_*          request handshake and fields (address and data unshifted)
//   RESP_*         one-cycle response strobe, load data, error flag
//   MEM_*          memory select/write enable (active-low), lane-shifted
//                  byte enables, word address, write data, read data, ack
// All outputs are registered.
// ============================================================================
module dmem_access_unit #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WEN,
    input  logic [3:0]        REQ_BE,
    input  logic [2:0]        REQ_LFUNCT,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RESP_VALID,
    output logic [31:0]       RESP_RDATA,
    output logic              RESP_ERR,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [3:0]        MEM_BE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA,
    input  logic              MEM_ACK
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Returns 1 for an illegal pattern/funct3 or a misaligned access.
    function automatic logic req_error(input logic       wen,
                                       input logic [3:0] be,
                                       input logic [2:0] lf,
                                       input logic [1:0] off);
        logic [1:0] size;
        logic       illegal;
        logic       misaligned;
        size    = 2'd0;
        illegal = 1'b0;
        if (wen == 1'b0) begin
            case (be)
                4'b0001: size = 2'd0;
                4'b0011: size = 2'd1;
                4'b1111: size = 2'd2;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (lf)
                3'b000, 3'b100: size = 2'd0;
                3'b001, 3'b101: size = 2'd1;
                3'b010:         size = 2'd2;
                default:        illegal = 1'b1;
            endcase
        end
        case (size)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

    // Brings the addressed lanes down to bit 0 and extends per funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  lf);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (lf)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b010:  r = s;
            3'b100:  r = {24'h000000, s[7:0]};
            3'b101:  r = {16'h0000, s[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_csn_q, mem_csn_d;
    logic              mem_wen_q, mem_wen_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        lfunct_q, lfunct_d;
    logic [1:0]        off_q, off_d;
    logic              accept_s;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Upper byte-address bits are deliberately dropped so addresses wrap.
    logic unused_addr_s;
    assign unused_addr_s = ^REQ_ADDR[31:ADDR_W+2];

    assign accept_s = (state_q == ST_IDLE) && ready_q && REQ_VALID;

    // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_csn_d    = mem_csn_q;
        mem_wen_d    = mem_wen_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        is_load_d    = is_load_q;
        lfunct_d     = lfunct_q;
        off_d        = off_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept_s) begin
                    ready_d   = 1'b0;
                    is_load_d = REQ_WEN;
                    lfunct_d  = REQ_LFUNCT;
                    off_d     = REQ_ADDR[1:0];
                    if (req_error(REQ_WEN, REQ_BE, REQ_LFUNCT, REQ_ADDR[1:0])) begin
                        // Rejected without touching memory.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end else begin
                        state_d    = ST_ACCESS;
                        mem_csn_d  = 1'b0;
                        mem_wen_d  = REQ_WEN;
                        mem_addr_d = REQ_ADDR[ADDR_W+1:2];
`ifdef DMEM_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                        if (REQ_WEN == 1'b0) begin
                            mem_be_d    = REQ_BE << REQ_ADDR[1:0];
                            mem_wdata_d = REQ_WDATA << {REQ_ADDR[1:0], 3'b000};
                        end else begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = 32'h0000_0000;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                ready_d = 1'b0;
                if (MEM_ACK) begin
                    state_d      = ST_RESP;
                    mem_csn_d    = 1'b1;
                    mem_wen_d    = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    if (is_load_q) begin
                        resp_rdata_d = load_extract(MEM_RDATA, off_q, lfunct_q);
                    end else begin
                        resp_rdata_d = 32'h0000_0000;
                    end
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    // cnt_q counts completed ACCESS cycles without an ack.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d      = ST_RESP;
                        mem_csn_d    = 1'b1;
                        mem_wen_d    = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = ST_ACCESS;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                ready_d   = 1'b0;
                mem_csn_d = 1'b1;
                mem_wen_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
            mem_csn_q    <= 1'b1;
            mem_wen_q    <= 1'b1;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0000_0000;
            is_load_q    <= 1'b0;
            lfunct_q     <= 3'b000;
            off_q        <= 2'b00;
`ifdef DMEM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_csn_q    <= mem_csn_d;
            mem_wen_q    <= mem_wen_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            is_load_q    <= is_load_d;
            lfunct_q     <= lfunct_d;
            off_q        <= off_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign REQ_READY  = ready_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_RDATA = resp_rdata_q;
    assign RESP_ERR   = resp_err_q;
    assign MEM_CSN    = mem_csn_q;
    assign MEM_WEN    = mem_wen_q;
    assign MEM_BE     = mem_be_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// tb_dmem_access_unit
//
// Directed-vector bench for dmem_access_unit. The bench plays the memory
// (MEM_ACK/MEM_RDATA) and the core. Expected values are hand-computed
// constants in the stimulus calls. Outputs are sampled 1 ns after the
// rising edge.
// ============================================================================
module tb_dmem_access_unit;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;

    logic              CLK;
    logic              RSTn;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WEN;
    logic [3:0]        REQ_BE;
    logic [2:0]        REQ_LFUNCT;
    logic [31:0]       REQ_ADDR;
    logic [31:0]       REQ_WDATA;
    logic              RESP_VALID;
    logic [31:0]       RESP_RDATA;
    logic              RESP_ERR;
    logic              MEM_CSN;
    logic              MEM_WEN;
    logic [3:0]        MEM_BE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic [31:0]       MEM_RDATA;
    logic              MEM_ACK;

    int n_checks;
    int n_fail;

    dmem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WEN    (REQ_WEN),
        .REQ_BE     (REQ_BE),
        .REQ_LFUNCT (REQ_LFUNCT),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .RESP_VALID (RESP_VALID),
        .RESP_RDATA (RESP_RDATA),
        .RESP_ERR   (RESP_ERR),
        .MEM_CSN    (MEM_CSN),
        .MEM_WEN    (MEM_WEN),
        .MEM_BE     (MEM_BE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .MEM_ACK    (MEM_ACK)
    );

    // Free-running 100 MHz clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete request. ack_wait = ACCESS cycles with MEM_ACK low before
    // the ack cycle. Error requests expect RESP in the cycle after acceptance.
    task automatic xfer(input string       tag,
                        input logic        wen,
                        input logic [3:0]  be,
                        input logic [2:0]  lf,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [31:0] rd,
                        input int          ack_wait,
                        input logic        exp_err,
                        input logic [3:0]  exp_be,
                        input logic [11:0] exp_maddr,
                        input logic [31:0] exp_mwdata,
                        input logic [31:0] exp_rdata);
        check_val({tag, "_ready"}, 32'(REQ_READY), 32'd1);
        REQ_VALID  = 1'b1;
        REQ_WEN    = wen;
        REQ_BE     = be;
        REQ_LFUNCT = lf;
        REQ_ADDR   = addr;
        REQ_WDATA  = wdata;
        step();
        REQ_VALID = 1'b0;
        REQ_WDATA = 32'h5555_AAAA;
        REQ_ADDR  = 32'hFFFF_FFFF;
        if (exp_err) begin
            check_val({tag, "_rvalid"}, 32'(RESP_VALID), 32'd1);
            check_val({tag, "_rerr"},   32'(RESP_ERR),   32'd1);
            check_val({tag, "_rdata"},  RESP_RDATA,      32'd0);
            check_val({tag, "_csn"},    32'(MEM_CSN),    32'd1);
            check_val({tag, "_rdy0"},   32'(REQ_READY),  32'd0);
            step();
            check_val({tag, "_rvalid1"}, 32'(RESP_VALID), 32'd0);
            check_val({tag, "_csn1"},    32'(MEM_CSN),    32'd1);
        end else begin
            check_val({tag, "_csn"},   32'(MEM_CSN),   32'd0);
            check_val({tag, "_wen"},   32'(MEM_WEN),   32'(wen));
            check_val({tag, "_be"},    32'(MEM_BE),    32'(exp_be));
            check_val({tag, "_maddr"}, 32'(MEM_ADDR),  32'(exp_maddr));
            check_val({tag, "_mwd"},   MEM_WDATA,      exp_mwdata);
            check_val({tag, "_rv0"},   32'(RESP_VALID), 32'd0);
            for (int i = 0; i < ack_wait; i++) begin
                step();
                check_val({tag, "_hold_csn"}, 32'(MEM_CSN), 32'd0);
                check_val({tag, "_hold_be"},  32'(MEM_BE),  32'(exp_be));
                check_val({tag, "_hold_rv"},  32'(RESP_VALID), 32'd0);
            end
            MEM_ACK   = 1'b1;
            MEM_RDATA = rd;
            step();
            MEM_ACK   = 1'b0;
            MEM_RDATA = 32'hBAD0_BAD0;
            check_val({tag, "_rvalid"}, 32'(RESP_VALID), 32'd1);
            check_val({tag, "_rerr"},   32'(RESP_ERR),   32'd0);
            check_val({tag, "_rdata"},  RESP_RDATA,      exp_rdata);
            check_val({tag, "_csn_rel"}, 32'(MEM_CSN),   32'd1);
            check_val({tag, "_wen_rel"}, 32'(MEM_WEN),   32'd1);
            check_val({tag, "_rdy_resp"}, 32'(REQ_READY), 32'd0);
            step();
            check_val({tag, "_rvalid1"}, 32'(RESP_VALID), 32'd0);
            check_val({tag, "_rdata_hold"}, RESP_RDATA, exp_rdata);
        end
        check_val({tag, "_ready_again"}, 32'(REQ_READY), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        RSTn       = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_WEN    = 1'b1;
        REQ_BE     = 4'b0000;
        REQ_LFUNCT = 3'b000;
        REQ_ADDR   = 32'h0000_0000;
        REQ_WDATA  = 32'h0000_0000;
        MEM_RDATA  = 32'h0000_0000;
        MEM_ACK    = 1'b0;
        step();
        step();
        check_val("rst_ready", 32'(REQ_READY),  32'd0);
        check_val("rst_csn",   32'(MEM_CSN),    32'd1);
        check_val("rst_wen",   32'(MEM_WEN),    32'd1);
        check_val("rst_be",    32'(MEM_BE),     32'd0);
        check_val("rst_maddr", 32'(MEM_ADDR),   32'd0);
        check_val("rst_mwd",   MEM_WDATA,       32'd0);
        check_val("rst_rv",    32'(RESP_VALID), 32'd0);
        check_val("rst_rdata", RESP_RDATA,      32'd0);
        check_val("rst_rerr",  32'(RESP_ERR),   32'd0);
        RSTn = 1'b1;
        step();
        check_val("post_rst_ready", 32'(REQ_READY), 32'd1);

        // Stores
        xfer("sw",  1'b0, 4'b1111, 3'b000, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0,
             1'b0, 4'b1111, 12'h041, 32'hDEAD_BEEF, 32'h0);
        xfer("sb",  1'b0, 4'b0001, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 2,
             1'b0, 4'b1000, 12'h040, 32'hA500_0000, 32'h0);
        xfer("sh",  1'b0, 4'b0011, 3'b000, 32'h0000_0102, 32'h0000_1234, 32'h0, 0,
             1'b0, 4'b1100, 12'h040, 32'h1234_0000, 32'h0);
        xfer("sw_wrap", 1'b0, 4'b1111, 3'b000, 32'h0000_4008, 32'h0BAD_CAFE, 32'h0, 1,
             1'b0, 4'b1111, 12'h002, 32'h0BAD_CAFE, 32'h0);

        // Loads
        xfer("lb101", 1'b1, 4'b0000, 3'b000, 32'h0000_0101, 32'h0, 32'h12F0_3456, 0,
             1'b0, 4'b1111, 12'h040, 32'h0, 32'h0000_0034);
        xfer("lb102", 1'b1, 4'b0000, 3'b000, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0,
             1'b0, 4'b1111, 12'h040, 32'h0, 32'hFFFF_FFF0);
        xfer("lbu102", 1'b1, 4'b0000, 3'b100, 32'h0000_0102, 32'h0, 32'h12F0_3456, 1,
             1'b0, 4'b1111, 12'h040, 32'h0, 32'h0000_00F0);
        xfer("lh102", 1'b1, 4'b0000, 3'b001, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0,
             1'b0, 4'b1111, 12'h040, 32'h0, 32'h0000_12F0);
        xfer("lh100", 1'b1, 4'b0000, 3'b001, 32'h0000_0100, 32'h0, 32'h12F0_8456, 0,
             1'b0, 4'b1111, 12'h040, 32'h0, 32'hFFFF_8456);
        xfer("lhu100", 1'b1, 4'b0000, 3'b101, 32'h0000_0100, 32'h0, 32'h12F0_8456, 0,
             1'b0, 4'b1111, 12'h040, 32'h0, 32'h0000_8456);
        xfer("lw200", 1'b1, 4'b0000, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 3,
             1'b0, 4'b1111, 12'h080, 32'h0, 32'hCAFE_F00D);

        // Error cases: no memory access, response one cycle after acceptance
        xfer("lw_mis", 1'b1, 4'b0000, 3'b010, 32'h0000_0106, 32'h0, 32'h0, 0,
             1'b1, 4'b0000, 12'h000, 32'h0, 32'h0);
        xfer("st_be0111", 1'b0, 4'b0111, 3'b000, 32'h0000_0100, 32'h1111_1111, 32'h0, 0,
             1'b1, 4'b0000, 12'h000, 32'h0, 32'h0);
        xfer("lh_mis", 1'b1, 4'b0000, 3'b001, 32'h0000_0103, 32'h0, 32'h0, 0,
             1'b1, 4'b0000, 12'h000, 32'h0, 32'h0);
        xfer("sh_mis", 1'b0, 4'b0011, 3'b000, 32'h0000_0101, 32'h0, 32'h0, 0,
             1'b1, 4'b0000, 12'h000, 32'h0, 32'h0);
        xfer("ld_f011", 1'b1, 4'b0000, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0,
             1'b1, 4'b0000, 12'h000, 32'h0, 32'h0);
        xfer("ld_f110", 1'b1, 4'b0000, 3'b110, 32'h0000_0100, 32'h0, 32'h0, 0,
             1'b1, 4'b0000, 12'h000, 32'h0, 32'h0);

`ifdef DMEM_TIMEOUT_EN
        // Ack on the last allowed ACCESS cycle still completes normally.
        xfer("lw_late", 1'b1, 4'b0000, 3'b010, 32'h0000_0300, 32'h0, 32'h1357_9BDF, TIMEOUT - 1,
             1'b0, 4'b1111, 12'h0C0, 32'h0, 32'h1357_9BDF);
        // No ack at all: CSN low for TIMEOUT cycles, then error response.
        REQ_VALID  = 1'b1;
        REQ_WEN    = 1'b1;
        REQ_LFUNCT = 3'b010;
        REQ_ADDR   = 32'h0000_0300;
        step();
        REQ_VALID = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            check_val("to_csn", 32'(MEM_CSN), 32'd0);
            check_val("to_rv",  32'(RESP_VALID), 32'd0);
            step();
        end
        check_val("to_rvalid", 32'(RESP_VALID), 32'd1);
        check_val("to_rerr",   32'(RESP_ERR),   32'd1);
        check_val("to_rdata",  RESP_RDATA,      32'd0);
        check_val("to_csn_rel", 32'(MEM_CSN),   32'd1);
        step();
        check_val("to_ready", 32'(REQ_READY), 32'd1);
`else
        // Without a timeout the unit waits for a slow memory.
        xfer("lw_slow", 1'b1, 4'b0000, 3'b010, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 20,
             1'b0, 4'b1111, 12'h0C0, 32'h0, 32'h1357_9BDF);
`endif

        // Reset during the 3rd ACCESS cycle of a load.
        REQ_VALID  = 1'b1;
        REQ_WEN    = 1'b1;
        REQ_LFUNCT = 3'b010;
        REQ_ADDR   = 32'h0000_0040;
        step();
        REQ_VALID = 1'b0;
        check_val("mr_csn1", 32'(MEM_CSN), 32'd0);
        step();
        step();
        check_val("mr_csn3", 32'(MEM_CSN), 32'd0);
        RSTn    = 1'b0;
        MEM_ACK = 1'b1;
        step();
        check_val("mr_csn_rst",   32'(MEM_CSN),    32'd1);
        check_val("mr_ready_rst", 32'(REQ_READY),  32'd0);
        check_val("mr_rv_rst",    32'(RESP_VALID), 32'd0);
        RSTn = 1'b1;
        step();
        check_val("mr_ready_back", 32'(REQ_READY),  32'd1);
        check_val("mr_rv_back",    32'(RESP_VALID), 32'd0);
        // MEM_ACK held high in IDLE must be ignored.
        step();
        check_val("idle_ack_rv",  32'(RESP_VALID), 32'd0);
        check_val("idle_ack_csn", 32'(MEM_CSN),    32'd1);
        MEM_ACK = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-side responder for the decoder's data-memory control outputs: active-low write enable, unshifted byte-enable pattern and load funct3.
- Accepts one load/store request per handshake and drives a single-port word-addressed data memory with an acknowledge.
- Aligns store lanes, extracts and sign/zero-extends load data, and flags misaligned or illegal accesses.
- Sits between the core datapath and data memory; the core stalls while REQ_READY is low.

Parameters:
ADDR_W, 12, memory word-address width (byte address bits [ADDR_W+1:2])
TIMEOUT, 15, max cycles in ACCESS waiting for MEM_ACK (used only with DMEM_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  reset, synchronous, active-low
REQ_VALID  in  1  request valid
REQ_READY  out  1  unit idle, request accepted when VALID&READY
REQ_WEN  in  1  0=store, 1=load (active-low write enable)
REQ_BE  in  4  store pattern, unshifted: 0001 SB, 0011 SH, 1111 SW
REQ_LFUNCT  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, unshifted (rs2)
RESP_VALID  out  1  one-cycle response strobe
RESP_RDATA  out  32  extended load data; 0 for stores/errors
RESP_ERR  out  1  misaligned/illegal/timeout, valid with RESP_VALID
MEM_CSN  out  1  memory select, active-low
MEM_WEN  out  1  memory write enable, active-low
MEM_BE  out  4  lane-shifted byte enables
MEM_ADDR  out  ADDR_W  word address
MEM_WDATA  out  32  lane-shifted store data
MEM_RDATA  in  32  memory read word, valid when MEM_ACK=1
MEM_ACK  in  1  memory completion

Behaviour:
- Reset (RSTn=0 at edge): state IDLE; REQ_READY=0 while RSTn=0, then 1. MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0, RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0. All outputs registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: REQ_READY=1. On VALID&READY, register all request fields and check:
  - Size: store BE 0001/0011/1111 = byte/half/word; load LFUNCT[1:0] 00/01/10 = byte/half/word.
  - Illegal: store BE outside the three patterns; load LFUNCT 011, 110 or 111.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Error -> RESP with ERR=1, no memory access (latency 1). Otherwise -> ACCESS.
- ACCESS:
  - REQ_READY=0, MEM_CSN=0, MEM_WEN=REQ_WEN, MEM_ADDR=addr[ADDR_W+1:2].
  - Stores: MEM_BE=BE<<addr[1:0], MEM_WDATA=wdata<<(8*addr[1:0]). Loads: MEM_BE=1111, MEM_WDATA=0.
  - Signals are held until MEM_ACK is sampled 1. That edge: capture load data (MEM_RDATA>>(8*addr[1:0]), sign-extend for 000/001, zero-extend for 100/101), deassert MEM_CSN/MEM_WEN, go to RESP.
- RESP: RESP_VALID=1 for exactly one cycle, REQ_READY=0, then IDLE. No response backpressure. RESP_RDATA/RESP_ERR hold their value until the next RESP.
- Latency: acceptance at edge T; ACK at the first ACCESS cycle gives RESP_VALID in cycle T+2. Back-to-back throughput is 1 request per 3 cycles.
- MEM_ACK in IDLE/RESP is ignored. REQ_VALID during ACCESS/RESP is not accepted and must be held by the core.
- Reset mid-ACCESS: transaction abandoned, MEM_CSN=1 the following cycle, no RESP issued.
- Address bits above ADDR_W+1 are ignored (wrap).

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined: a counter runs in ACCESS. If MEM_ACK has not been seen after TIMEOUT cycles, the unit releases MEM_CSN and goes to RESP with ERR=1, RDATA=0.
- Undefined: no counter; ACCESS waits indefinitely for MEM_ACK, and RESP_ERR reports only misaligned/illegal accesses.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, ACK in the first ACCESS cycle -> MEM_WEN=0, MEM_BE=1111, MEM_ADDR=0x041, MEM_WDATA=0xDEADBEEF; RESP_VALID at T+2, ERR=0.
- SB addr 0x103, wdata 0x000000A5 -> MEM_BE=1000, MEM_WDATA=0xA5000000; SH addr 0x102, wdata 0x1234 -> MEM_BE=1100, MEM_WDATA=0x12340000.
- MEM_RDATA=0x12F03456 at addr 0x101: LB -> 0x00000034; at addr 0x102: LB -> 0xFFFFFFF0, LBU -> 0x000000F0, LH -> 0x000012F0.
- LW addr 0x106, and store with BE=0111 -> RESP_VALID at T+1, ERR=1, MEM_CSN stays 1 throughout.
- DMEM_TIMEOUT_EN, TIMEOUT=15, MEM_ACK held 0 -> MEM_CSN=0 for 15 cycles, then RESP_VALID=1, ERR=1, MEM_CSN=1.
- RSTn=0 during the 3rd ACCESS cycle of a load -> next cycle MEM_CSN=1, REQ_READY=0; no RESP_VALID; REQ_READY=1 one cycle after RSTn returns 1.
